mc_ctrl_fsm: RTL and testbench

Multicycle MIPS main control unit. It is the producer of the `branch` / PC-write control signals that the downstream branch-condition gating consumes.
- Sequences each instruction through IF/ID/EX/MEM/WB states.
- Emits per-state datapath controls: PC, memory, IR, register file, ALU muxes and branch qualifier.
- Sits between the instruction register (opcode in) and the datapath muxes and enables.

---
 rtl/mc_ctrl_pkg.sv | 57 +++++
 rtl/mc_ctrl_fsm_if.sv | 49 ++++
 rtl/mc_ctrl_decode.sv | 65 ++++++
 rtl/mc_ctrl_fsm.sv | 102 ++++++++++
 tb/tb_mc_ctrl_fsm.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit:
// state codes, opcodes, datapath mux encodings and the control word.
package mc_ctrl_pkg;

    localparam logic [3:0] S_IF      = 4'd0;
    localparam logic [3:0] S_ID      = 4'd1;
    localparam logic [3:0] S_EX_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD  = 4'd3;
    localparam logic [3:0] S_MEM_WR  = 4'd4;
    localparam logic [3:0] S_WB_LW   = 4'd5;
    localparam logic [3:0] S_WB_I    = 4'd6;
    localparam logic [3:0] S_EX_R    = 4'd7;
    localparam logic [3:0] S_WB_R    = 4'd8;
    localparam logic [3:0] S_EX_BR   = 4'd9;
    localparam logic [3:0] S_EX_J    = 4'd10;
    localparam logic [3:0] S_TRAP    = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSA = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_SEXT  = 2'b10;
    localparam logic [1:0] SRCB_SEXT2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       br_sel;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the main control FSM and the datapath.
// illegal_op exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
interface mc_ctrl_fsm_if #(
    parameter int OP_W = 6
);
    logic [OP_W-1:0] opcode;
    logic            pc_write;
    logic            branch;
    logic            br_sel;
    logic            iord;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [1:0]      pc_source;
    logic [3:0]      state_o;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic            illegal_op;
`endif

    modport master (
        input  opcode,
        output pc_write, branch, br_sel, iord,
        output mem_read, mem_write, ir_write,
        output reg_dst, mem_to_reg, reg_write,
        output alu_src_a, alu_src_b, alu_op,
        output pc_source, state_o
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , output illegal_op
`endif
    );

    modport slave (
        output opcode,
        input  pc_write, branch, br_sel, iord,
        input  mem_read, mem_write, ir_write,
        input  reg_dst, mem_to_reg, reg_write,
        input  alu_src_a, alu_src_b, alu_op,
        input  pc_source, state_o
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , input illegal_op
`endif
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state (+ opcode in EX_BR) to control word decoder.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [3:0]      state_i,
    input  logic            last_i,
    input  logic [OP_W-1:0] opcode_i,
    output ctrl_t           ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_IF: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_4;
                ctrl_o.ir_write  = last_i;
                ctrl_o.pc_write  = last_i;
            end
            S_ID: ctrl_o.alu_src_b = SRCB_SEXT2;
            S_EX_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = last_i;
            end
            S_WB_LW: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_WB_I: ctrl_o.reg_write = 1'b1;
            S_EX_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_WB_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_EX_BR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.branch    = 1'b1;
                ctrl_o.pc_source = PCS_ALUOUT;
                // bgtz tests A directly, beq subtracts
                ctrl_o.br_sel = (opcode_i == OP_BGTZ);
                ctrl_o.alu_op = (opcode_i == OP_BGTZ)
                              ? ALU_PASSA : ALU_SUB;
            end
            S_EX_J: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCS_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control: state register, wait counter, next state.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes (illegal_op).
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 0,
    parameter int OP_W    = 6
) (
    input logic         clk,
    input logic         reset,
    mc_ctrl_fsm_if.master bus
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    logic [3:0] state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       last;
    ctrl_t      dec, ctrl;

    assign last = (wait_q == LAT);

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        unique case (state_q)
            S_IF: begin
                if (last) state_d = S_ID;
                else      wait_d  = wait_q + 4'd1;
            end
            S_ID: begin
                unique case (bus.opcode)
                    OP_LW, OP_SW, OP_ADDI: state_d = S_EX_ADDR;
                    OP_R:                  state_d = S_EX_R;
                    OP_BEQ, OP_BGTZ:       state_d = S_EX_BR;
                    OP_J:                  state_d = S_EX_J;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:               state_d = S_TRAP;
`else
                    default:               state_d = S_IF;
`endif
                endcase
            end
            S_EX_ADDR: begin
                if (bus.opcode == OP_LW)      state_d = S_MEM_RD;
                else if (bus.opcode == OP_SW) state_d = S_MEM_WR;
                else                          state_d = S_WB_I;
            end
            S_MEM_RD: begin
                if (last) state_d = S_WB_LW;
                else      wait_d  = wait_q + 4'd1;
            end
            S_MEM_WR: begin
                if (last) state_d = S_IF;
                else      wait_d  = wait_q + 4'd1;
            end
            S_EX_R:  state_d = S_WB_R;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    mc_ctrl_decode #(.OP_W(OP_W)) u_decode (
        .state_i  (state_q),
        .last_i   (last),
        .opcode_i (bus.opcode),
        .ctrl_o   (dec)
    );

    // Reset forces every strobe and select low, even mid-instruction
    assign ctrl = reset ? '0 : dec;

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.branch     = ctrl.branch;
    assign bus.br_sel     = ctrl.br_sel;
    assign bus.iord       = ctrl.iord;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_source  = ctrl.pc_source;
    assign bus.state_o    = state_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal_op = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm at MEM_LAT = 0, 2 and 3.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, br, bsel, iord, mrd, mwr, irw;
        logic rdst, m2r, rw, srca;
        logic [1:0] srcb, aop, pcs;
    } obs_t;

    typedef struct {
        int         k;
        logic [5:0] op;
        int         cyc;
        logic [3:0] st;
        logic [5:0] strb;
        logic [1:0] aop;
        logic [1:0] pcs;
        logic       bsel;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst [3];
    logic [5:0] opc [3];
    obs_t       got [3];
    logic       ill [3];
    int         nchk = 0;
    int         nfail = 0;
    obs_t       exp_q [$];
    vec_t       vt [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        mc_ctrl_fsm_if ifc ();
        mc_ctrl_fsm #(.MEM_LAT(LAT), .OP_W(6)) u_dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (ifc)
        );
        assign ifc.opcode = opc[g];
        assign got[g] = {ifc.state_o, ifc.pc_write, ifc.branch,
                         ifc.br_sel, ifc.iord, ifc.mem_read,
                         ifc.mem_write, ifc.ir_write, ifc.reg_dst,
                         ifc.mem_to_reg, ifc.reg_write, ifc.alu_src_a,
                         ifc.alu_src_b, ifc.alu_op, ifc.pc_source};
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        assign ill[g] = ifc.illegal_op;
`else
        assign ill[g] = 1'b0;
`endif
    end

    function automatic int lat_of(int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    function automatic logic [5:0] strb_of(obs_t o);
        return {o.pcw, o.br, o.mrd, o.mwr, o.irw, o.rw};
    endfunction

    function automatic obs_t blank(logic [3:0] st);
        obs_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic bit legal(logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_BGTZ || op == OP_J ||
               op == OP_ADDI;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected per-cycle controls of one whole instruction
    task automatic model_instr(logic [5:0] op, int lat);
        obs_t e;
        for (int i = 0; i <= lat; i++) begin
            e = blank(S_IF);
            e.mrd = 1; e.srcb = 2'b01;
            e.irw = (i == lat); e.pcw = (i == lat);
            exp_q.push_back(e);
        end
        e = blank(S_ID); e.srcb = 2'b11; exp_q.push_back(e);
        if (op == OP_LW || op == OP_SW || op == OP_ADDI) begin
            e = blank(S_EX_ADDR); e.srca = 1; e.srcb = 2'b10;
            exp_q.push_back(e);
            if (op == OP_LW) begin
                for (int i = 0; i <= lat; i++) begin
                    e = blank(S_MEM_RD); e.mrd = 1; e.iord = 1;
                    exp_q.push_back(e);
                end
                e = blank(S_WB_LW); e.rw = 1; e.m2r = 1;
                exp_q.push_back(e);
            end else if (op == OP_SW) begin
                for (int i = 0; i <= lat; i++) begin
                    e = blank(S_MEM_WR); e.iord = 1; e.mwr = (i == lat);
                    exp_q.push_back(e);
                end
            end else begin
                e = blank(S_WB_I); e.rw = 1; exp_q.push_back(e);
            end
        end else if (op == OP_R) begin
            e = blank(S_EX_R); e.srca = 1; e.aop = 2'b10;
            exp_q.push_back(e);
            e = blank(S_WB_R); e.rw = 1; e.rdst = 1;
            exp_q.push_back(e);
        end else if (op == OP_BEQ || op == OP_BGTZ) begin
            e = blank(S_EX_BR); e.srca = 1; e.br = 1; e.pcs = 2'b01;
            e.bsel = (op == OP_BGTZ);
            e.aop = (op == OP_BGTZ) ? 2'b11 : 2'b01;
            exp_q.push_back(e);
        end else if (op == OP_J) begin
            e = blank(S_EX_J); e.pcw = 1; e.pcs = 2'b10;
            exp_q.push_back(e);
        end
    endtask

    // Leaves the caller just after the edge that starts IF cycle 1
    task automatic do_reset(int k);
        @(posedge clk); #1;
        rst[k] = 1'b1; opc[k] = '0;
        @(posedge clk); #1;
        rst[k] = 1'b0;
    endtask

    task automatic addv(int k, logic [5:0] op, int cyc, logic [3:0] st,
                        logic [5:0] strb, logic [1:0] aop,
                        logic [1:0] pcs, logic bsel);
        vec_t v;
        v.k = k; v.op = op; v.cyc = cyc; v.st = st; v.strb = strb;
        v.aop = aop; v.pcs = pcs; v.bsel = bsel;
        vt.push_back(v);
    endtask

    initial begin
        obs_t o, e;
        logic [5:0] op;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; opc[k] = '0;
        end

        addv(0, OP_LW,   1, S_IF,      6'b101010, 2'b00, 2'b00, 0);
        addv(0, OP_LW,   2, S_ID,      6'b000000, 2'b00, 2'b00, 0);
        addv(0, OP_LW,   3, S_EX_ADDR, 6'b000000, 2'b00, 2'b00, 0);
        addv(0, OP_LW,   4, S_MEM_RD,  6'b001000, 2'b00, 2'b00, 0);
        addv(0, OP_LW,   5, S_WB_LW,   6'b000001, 2'b00, 2'b00, 0);
        addv(0, OP_LW,   6, S_IF,      6'b101010, 2'b00, 2'b00, 0);
        addv(1, OP_SW,   1, S_IF,      6'b001000, 2'b00, 2'b00, 0);
        addv(1, OP_SW,   3, S_IF,      6'b101010, 2'b00, 2'b00, 0);
        addv(1, OP_SW,   4, S_ID,      6'b000000, 2'b00, 2'b00, 0);
        addv(1, OP_SW,   6, S_MEM_WR,  6'b000000, 2'b00, 2'b00, 0);
        addv(1, OP_SW,   8, S_MEM_WR,  6'b000100, 2'b00, 2'b00, 0);
        addv(1, OP_SW,   9, S_IF,      6'b001000, 2'b00, 2'b00, 0);
        addv(0, OP_BGTZ, 3, S_EX_BR,   6'b010000, 2'b11, 2'b01, 1);
        addv(0, OP_BEQ,  3, S_EX_BR,   6'b010000, 2'b01, 2'b01, 0);
        addv(0, OP_J,    3, S_EX_J,    6'b100000, 2'b00, 2'b10, 0);
        addv(0, OP_J,    4, S_IF,      6'b101010, 2'b00, 2'b00, 0);
        addv(0, OP_R,    3, S_EX_R,    6'b000000, 2'b10, 2'b00, 0);
        addv(0, OP_R,    4, S_WB_R,    6'b000001, 2'b00, 2'b00, 0);
        addv(0, OP_ADDI, 4, S_WB_I,    6'b000001, 2'b00, 2'b00, 0);
        addv(0, 6'h3f,   2, S_ID,      6'b000000, 2'b00, 2'b00, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        addv(0, 6'h3f,   3, S_TRAP,    6'b000000, 2'b00, 2'b00, 0);
`else
        addv(0, 6'h3f,   3, S_IF,      6'b101010, 2'b00, 2'b00, 0);
`endif

        foreach (vt[i]) begin
            do_reset(vt[i].k);
            opc[vt[i].k] = vt[i].op;
            for (int c = 1; c < vt[i].cyc; c++) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            o = got[vt[i].k];
            chk($sformatf("vec%0d", i),
                {13'd0, o.st, strb_of(o), o.aop, o.pcs, o.bsel},
                {13'd0, vt[i].st, vt[i].strb, vt[i].aop, vt[i].pcs,
                 vt[i].bsel});
        end

        // Reset during the 2nd MEM_RD cycle at MEM_LAT=3
        do_reset(2);
        opc[2] = OP_LW;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst[2] = 1'b1;
        @(negedge clk);
        o = got[2];
        chk("rst_mid_state", {28'd0, o.st}, {28'd0, S_MEM_RD});
        o.st = '0;
        chk("rst_mid_outputs_zero", 32'(o), 32'd0);
        @(posedge clk); #1;
        rst[2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            o = got[2];
            chk($sformatf("rst_if_c%0d", c),
                {26'd0, o.st, o.irw, o.mrd},
                {26'd0, S_IF, (c == 3), 1'b1});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_then_id", {28'd0, got[2].st}, {28'd0, S_ID});

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        do_reset(0);
        opc[0] = 6'h3f;
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            o = got[0];
            chk($sformatf("trap_c%0d", c),
                {26'd0, ill[0], strb_of(o)}, {26'd0, 1'b1, 6'd0});
            @(posedge clk); #1;
        end
        do_reset(0);
        @(negedge clk);
        chk("trap_cleared", {27'd0, ill[0], got[0].st}, {27'd0, 1'b0, S_IF});
`endif

        // Random instruction streams against the model
        for (int k = 0; k < 3; k++) begin
            do_reset(k);
            for (int n = 0; n < 30; n++) begin
                case ($urandom_range(0, 7))
                    0: op = OP_R;
                    1: op = OP_LW;
                    2: op = OP_SW;
                    3: op = OP_BEQ;
                    4: op = OP_BGTZ;
                    5: op = OP_J;
                    6: op = OP_ADDI;
                    default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        op = OP_ADDI;
`else
                        do op = 6'($urandom); while (legal(op));
`endif
                    end
                endcase
                exp_q.delete();
                model_instr(op, lat_of(k));
                for (int c = 0; exp_q.size() > 0; c++) begin
                    e = exp_q.pop_front();
                    opc[k] = (c <= lat_of(k)) ? 6'($urandom) : op;
                    @(negedge clk);
                    chk($sformatf("rand k%0d op%b c%0d", k, op, c),
                        32'(got[k]), 32'(e));
                    @(posedge clk); #1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
